seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

- Downstream display stage for the regressive counter.
- Consumes the counter's binary `count` as `value`, converts it to BCD sequentially (shift-and-add-3) and time-multiplexes the decimal digits onto a common-anode 7-segment display.
- Output polarity is active-low.
- Sits between the counter and the board pins, in the same clock and reset domain as the counter.

## Interface
Parameters:
- `N`, default 4: width of `value`; matches the counter's `N`.
- `DIGITS`, default 2: number of displayed digits. Must satisfy 10^DIGITS ≥ 2^N; elaboration `$error` otherwise.
- `REFRESH`, default 50000: clock cycles each digit stays enabled. Minimum 2.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `value`, input, N: binary number to display. Driven directly by the counter; treated as synchronous to `clk`.
- `seg`, output, 7: segments, active-low, bit0=a … bit6=g.
- `an`, output, DIGITS: digit enables, active-low, one-hot-low. Bit0 is the least-significant digit.
- `busy`, output, 1: high while a conversion is in progress.

## Operation
Conversion FSM, states IDLE and SHIFT:
- **IDLE:** if `value != last_q`, the edge does three things:
  - latch `value` into the shift register and into `last_q`;
  - clear the BCD scratch and the bit counter;
  - go to SHIFT.
- **SHIFT:** on each edge, add 3 to every scratch nibble ≥ 5, then shift the {scratch, shift} pair left by one.
  - On the Nth SHIFT edge, write the final scratch into `bcd_q` (atomic, all digits at once) and go to IDLE.
- `value` changes during SHIFT are ignored. On return to IDLE the compare is re-evaluated, so the newest value is converted next. `bcd_q` never holds a partial result.
- `busy` = (state == SHIFT).

Scan:
- `rcnt` counts 0..REFRESH-1 continuously. At REFRESH-1 it wraps to 0 and `idx` advances, with DIGITS-1 wrapping to 0.
- Registered outputs:
  - `an` ← all ones except bit `idx` = 0;
  - `seg` ← decode(`bcd_q` nibble `idx`).
- Active-low decode: 0=7'h40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Nibbles > 9 decode to 7'h7F (blank).

## Timing
- Reset values (asserted immediately, no clock needed):
  - `an` = all ones, `seg` = 7'h7F, `busy` = 0;
  - state IDLE, `last_q` = 0, `bcd_q` = 0;
  - `idx` = 0, `rcnt` = 0.
- First edge after reset release: `an` = ~1 (digit0 on), `seg` = 7'h40.
- Conversion latency:
  - `value` presented before edge k → load at edge k;
  - `bcd_q` updated at edge k+N, so N+1 edges total;
  - the result reaches `seg` on the first edge at which that digit is the selected one.
- Back-to-back changes: the new load occurs at edge k+N+1 at the earliest.
- Digit dwell is exactly REFRESH cycles; full frame is DIGITS×REFRESH cycles.
- `seg`/`an` change together on the same edge, so there is no cycle where `an` selects a digit while `seg` shows a different digit's pattern.
- Reset asserted mid-conversion: the partial result is discarded. After release, `value` is reconverted if it is non-zero.

## Configuration
- `SEG7_LEADING_ZERO_BLANK_EN` defined:
  - any digit above the most-significant non-zero digit of `bcd_q` is blanked: `an` bit stays 1 and `seg` = 7'h7F during its slot;
  - digit0 is always shown, so value 0 displays "0".
- Not defined: all DIGITS digits are always enabled and show leading zeros.
- The slot timing is identical in both cases.

## Test plan
Bench parameters: N=4, DIGITS=2, REFRESH=4.

- **Reset:** hold `reset` low → `an`=2'b11, `seg`=7'h7F, `busy`=0. Release → next edge `an`=2'b10, `seg`=7'h40.
- **Full value:** `value`=15 steady → `busy` high 4 cycles, `bcd_q`=8'h15. Digit0 slot `seg`=7'h12, digit1 slot `seg`=7'h79. `an` toggles every 4 cycles.
- **Change during conversion:** `value` 15 → 9 on the 2nd SHIFT cycle → `bcd_q` first becomes 8'h15, then a second conversion gives 8'h09. No other `bcd_q` value appears.
- **Leading zeros:** `value`=7. With macro: digit1 slot `an`=2'b11, `seg`=7'h7F. Without macro: digit1 slot `an`=2'b01, `seg`=7'h40.
- **Zero with macro:** `value`=0 → digit0 shows 7'h40, digit1 is blanked.
- **Async reset mid-operation:** assert `reset` mid-SHIFT and mid-slot, between clock edges → outputs go to reset values immediately. After release, `value`=12 gives `bcd_q`=8'h12 within 5 edges.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Interface bundling the display-side signals of seg7_scan_driver.
//   value : binary number to display (driven by the counter)
//   seg   : active-low segments, bit0=a .. bit6=g
//   an    : active-low one-hot digit enables, bit0 = least-significant digit
//   busy  : high while a binary-to-BCD conversion is running
// Modports: master = counter/board side, slave = seg7_scan_driver.
interface seg7_scan_driver_if #(
  parameter int unsigned N      = 4,
  parameter int unsigned DIGITS = 2
) ();

  logic [N-1:0]      value;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;
  logic              busy;

  modport master (
    output value,
    input  seg,
    input  an,
    input  busy
  );

  modport slave (
    input  value,
    output seg,
    output an,
    output busy
  );

endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: converts a binary value to BCD with a sequential shift-and-add-3
// engine and time-multiplexes the decimal digits onto a common-anode 7-segment display.
//
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : seg7_scan_driver_if.slave (value in; seg, an, busy out)
//
// Parameters: N (value width), DIGITS (displayed digits, 10^DIGITS >= 2^N),
//             REFRESH (cycles per digit slot, >= 2).
//
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank digits above the
// most-significant non-zero BCD digit (digit0 always shown).
module seg7_scan_driver #(
  parameter int unsigned N       = 4,
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned REFRESH = 50000
) (
  input logic               clk,
  input logic               reset,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned RW = $clog2(REFRESH);
  localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;

  function automatic bit digits_fit(input int unsigned n, input int unsigned d);
    longint unsigned p10;
    p10 = 1;
    for (int unsigned i = 0; i < d; i++) p10 = p10 * 10;
    return p10 >= (64'd1 << n);
  endfunction

  if (!digits_fit(N, DIGITS)) begin : g_bad_digits
    $error("seg7_scan_driver: DIGITS too small for N-bit value");
  end
  if (REFRESH < 2) begin : g_bad_refresh
    $error("seg7_scan_driver: REFRESH must be at least 2");
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  // Conversion state
  state_e        state_q, state_d;
  logic [N-1:0]  last_q, last_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [SW-1:0] scratch_q, scratch_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [SW-1:0] bcd_q, bcd_d;

  // Scan state
  logic [RW-1:0]     rcnt_q, rcnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic [SW-1:0]   adj;
  logic [SW+N-1:0] shift_pair;
  logic [SW-1:0]   scratch_shift;
  logic [N-1:0]    shift_next;
  logic [3:0]      nib;

  // Add-3 correction on every nibble >= 5, then shift {scratch, shift} left by one.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    shift_pair    = {adj, shift_q} << 1;
    scratch_shift = shift_pair[SW+N-1:N];
    shift_next    = shift_pair[N-1:0];
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    bcnt_d    = bcnt_q;
    bcd_d     = bcd_q;
    unique case (state_q)
      StIdle: begin
        if (bus.value != last_q) begin
          shift_d   = bus.value;
          last_d    = bus.value;
          scratch_d = '0;
          bcnt_d    = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        shift_d   = shift_next;
        scratch_d = scratch_shift;
        if (bcnt_q == BW'(N - 1)) begin
          // Whole result lands at once so bcd_q never shows a partial value.
          bcd_d   = scratch_shift;
          state_d = StIdle;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rcnt_d = rcnt_q + 1'b1;
    idx_d  = idx_q;
    if (rcnt_q == RW'(REFRESH - 1)) begin
      rcnt_d = '0;
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // an and seg both derive from the same idx_q so they always switch together.
  always_comb begin
    nib  = '0;
    an_d = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IW'(i)) begin
        nib     = bcd_q[4*i +: 4];
        an_d[i] = 1'b0;
      end
    end
    seg_d = seg_decode(nib);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    begin
      logic [IW-1:0] msd;
      msd = '0;
      for (int i = 1; i < int'(DIGITS); i++) begin
        if (bcd_q[4*i +: 4] != 4'd0) msd = IW'(i);
      end
      if (idx_q > msd) begin
        an_d  = '1;
        seg_d = 7'h7F;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      last_q    <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      bcnt_q    <= '0;
      bcd_q     <= '0;
      rcnt_q    <= '0;
      idx_q     <= '0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      bcnt_q    <= bcnt_d;
      bcd_q     <= bcd_d;
      rcnt_q    <= rcnt_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.seg  = seg_q;
  assign bus.an   = an_q;
  assign bus.busy = (state_q == StShift);

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with N=4, DIGITS=2, REFRESH=4.
module tb_seg7_scan_driver;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit LzBlank = 1'b1;
`else
  localparam bit LzBlank = 1'b0;
`endif

  logic clk;
  logic reset;

  seg7_scan_driver_if #(.N(4), .DIGITS(2)) bus ();

  seg7_scan_driver #(
    .N      (4),
    .DIGITS (2),
    .REFRESH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_total;
  int unsigned n_bad;
  int unsigned ecnt;  // rising edges since the last reset release

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    ecnt++;
    @(negedge clk);
  endtask

  // Checks two full frames; slot of edge e is ((e-1)/4)%2 since reset release.
  task automatic check_scan(input string tag, input logic [6:0] seg0, input logic [6:0] seg1,
                            input bit blank1);
    int unsigned slot;
    for (int i = 0; i < 8; i++) begin
      step();
      slot = ((ecnt - 1) / 4) % 2;
      if (slot == 0) begin
        check_eq($sformatf("%s_an0_%0d", tag, i), 32'(bus.an), 32'h2);
        check_eq($sformatf("%s_seg0_%0d", tag, i), 32'(bus.seg), 32'(seg0));
      end else if (blank1) begin
        check_eq($sformatf("%s_an1b_%0d", tag, i), 32'(bus.an), 32'h3);
        check_eq($sformatf("%s_seg1b_%0d", tag, i), 32'(bus.seg), 32'h7F);
      end else begin
        check_eq($sformatf("%s_an1_%0d", tag, i), 32'(bus.an), 32'h1);
        check_eq($sformatf("%s_seg1_%0d", tag, i), 32'(bus.seg), 32'(seg1));
      end
    end
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    ecnt      = 0;
    reset     = 1'b1;
    bus.value = 4'd0;
    #1 reset = 1'b0;
    #1;
    check_eq("rst_an", 32'(bus.an), 32'h3);
    check_eq("rst_seg", 32'(bus.seg), 32'h7F);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    repeat (3) @(negedge clk);
    check_eq("rst_hold_an", 32'(bus.an), 32'h3);
    check_eq("rst_hold_seg", 32'(bus.seg), 32'h7F);

    // Release and first edge
    reset = 1'b1;
    ecnt  = 0;
    step();
    check_eq("rel_an", 32'(bus.an), 32'h2);
    check_eq("rel_seg", 32'(bus.seg), 32'h40);
    check_eq("rel_busy", 32'(bus.busy), 32'h0);
    check_scan("init", 7'h40, 7'h40, LzBlank);

    // Full value 15: busy for 4 cycles, bcd 0x15 at load+4
    bus.value = 4'd15;
    step();
    check_eq("v15_busy_load", 32'(bus.busy), 32'h1);
    for (int i = 1; i < 4; i++) begin
      step();
      check_eq($sformatf("v15_busy_%0d", i), 32'(bus.busy), 32'h1);
      check_eq($sformatf("v15_bcd_partial_%0d", i), 32'(dut.bcd_q), 32'h00);
    end
    step();
    check_eq("v15_busy_done", 32'(bus.busy), 32'h0);
    check_eq("v15_bcd", 32'(dut.bcd_q), 32'h15);
    step();
    check_scan("v15", 7'h12, 7'h79, 1'b0);

    // Change during conversion: 15 then 9 on the 2nd SHIFT cycle
    bus.value = 4'd0;
    repeat (6) step();
    check_eq("v0_bcd", 32'(dut.bcd_q), 32'h00);
    bus.value = 4'd15;
    step();
    step();
    bus.value = 4'd9;
    for (int s = 2; s <= 9; s++) begin
      step();
      if (s < 4) check_eq($sformatf("chg_bcd_%0d", s), 32'(dut.bcd_q), 32'h00);
      else if (s < 9) check_eq($sformatf("chg_bcd_%0d", s), 32'(dut.bcd_q), 32'h15);
      else check_eq($sformatf("chg_bcd_%0d", s), 32'(dut.bcd_q), 32'h09);
      if (s == 5) check_eq("chg_reload_busy", 32'(bus.busy), 32'h1);
    end
    step();
    check_scan("v9", 7'h10, 7'h40, LzBlank);

    // Zero
    bus.value = 4'd0;
    repeat (6) step();
    check_eq("z_bcd", 32'(dut.bcd_q), 32'h00);
    check_scan("v0", 7'h40, 7'h40, LzBlank);

    // Leading zero on 7
    bus.value = 4'd7;
    repeat (6) step();
    check_eq("v7_bcd", 32'(dut.bcd_q), 32'h07);
    check_scan("v7", 7'h78, 7'h40, LzBlank);

    // Async reset mid-SHIFT, between clock edges
    bus.value = 4'd12;
    step();
    step();
    check_eq("ar_busy_pre", 32'(bus.busy), 32'h1);
    #2 reset = 1'b0;
    #1;
    check_eq("ar_an", 32'(bus.an), 32'h3);
    check_eq("ar_seg", 32'(bus.seg), 32'h7F);
    check_eq("ar_busy", 32'(bus.busy), 32'h0);
    check_eq("ar_bcd", 32'(dut.bcd_q), 32'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    ecnt  = 0;
    step();
    check_eq("ar_rel_an", 32'(bus.an), 32'h2);
    check_eq("ar_rel_seg", 32'(bus.seg), 32'h40);
    check_eq("ar_rel_busy", 32'(bus.busy), 32'h1);
    for (int s = 2; s <= 4; s++) begin
      step();
      check_eq($sformatf("ar_bcd_%0d", s), 32'(dut.bcd_q), 32'h00);
    end
    step();
    check_eq("ar_bcd_5", 32'(dut.bcd_q), 32'h12);
    step();
    check_scan("v12", 7'h24, 7'h79, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
